memory_access: RTL

Memory-stage data-bus engine, directly downstream of execute. Takes the instruction latched into the M register (ALU address, store data, access control), issues a data-bus request with valid/addr_ok/data_ok handshakes, and aligns and extends load data. While an access is outstanding it holds the pipeline through the hazard unit. It also raises address-error exceptions for misaligned accesses.

---
 rtl/memory_access.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-stage data-bus engine: one valid/addr_ok/data_ok transaction per load or
// store, with load alignment/extension, pipeline stall and address-error detection.
module memory_access (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        flush,
  input  logic        hold,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [1:0]  dreq_size,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [31:0] dresp_data,
  output logic [31:0] rdata,
  output logic        done,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] badvaddr
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t      state;
  logic        kill_q;
  logic        drain_pending;

  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  size_q;
  logic [3:0]  strobe_q;
  logic        sign_ext_q;
  logic        is_load_q;

  logic        misaligned;
  logic        access;
  logic [3:0]  strobe_c;
  logic [31:0] data_c;

  logic        in_idle;
  logic [1:0]  cur_size;
  logic [1:0]  cur_off;
  logic        cur_sext;
  logic        cur_load;
  logic [31:0] shifted;
  logic [31:0] load_value;
  logic        complete;
  logic        kill_now;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    misaligned = 1'b0;
    unique case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = addr[0];
      default: misaligned = |addr[1:0];
    endcase
  end

  assign access   = valid_i & (mem_read | mem_write) & ~misaligned & ~flush;
  assign exc_adel = valid_i & mem_read & misaligned;
  assign exc_ades = valid_i & mem_write & misaligned;
  assign badvaddr = addr;

  // Store lane encoding; size 3 falls through to the word encoding.
  always_comb begin
    strobe_c = 4'h0;
    data_c   = wdata;
    if (mem_write) begin
      unique case (size)
        2'd0: begin
          strobe_c = 4'b0001 << addr[1:0];
          data_c   = {4{wdata[7:0]}};
        end
        2'd1: begin
          strobe_c = 4'b0011 << {addr[1], 1'b0};
          data_c   = {2{wdata[15:0]}};
        end
        default: begin
          strobe_c = 4'hF;
          data_c   = wdata;
        end
      endcase
    end
  end

  // In IDLE the request goes out straight from the M register; afterwards the latched copy is held.
  assign in_idle     = (state == IDLE);
  assign dreq_valid  = in_idle ? access : (state == REQ);
  assign dreq_addr   = in_idle ? addr     : addr_q;
  assign dreq_size   = in_idle ? size     : size_q;
  assign dreq_strobe = in_idle ? strobe_c : strobe_q;
  assign dreq_data   = in_idle ? data_c   : data_q;

  assign cur_size = in_idle ? size       : size_q;
  assign cur_off  = in_idle ? addr[1:0]  : addr_q[1:0];
  assign cur_sext = in_idle ? sign_ext   : sign_ext_q;
  assign cur_load = in_idle ? mem_read   : is_load_q;

  assign shifted = dresp_data >> {cur_off, 3'b000};

  always_comb begin
    load_value = shifted;
    unique case (cur_size)
      2'd0: load_value = cur_sext ? {{24{shifted[7]}}, shifted[7:0]}
                                  : {24'h0, shifted[7:0]};
      2'd1: load_value = cur_sext ? {{16{shifted[15]}}, shifted[15:0]}
                                  : {16'h0, shifted[15:0]};
      default: load_value = shifted;
    endcase
  end

  // data_ok without a prior or simultaneous addr_ok is ignored.
  assign complete = (((in_idle & access) | (state == REQ)) & dresp_addr_ok & dresp_data_ok)
                  | ((state == WAIT) & dresp_data_ok);
  assign kill_now = kill_q | flush;

  // A drained slot also holds back a fresh access for one cycle so it is not lost.
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:    stall = access;
      REQ:     stall = 1'b1;
      WAIT:    stall = 1'b1;
      DRAIN:   stall = drain_pending | access;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      kill_q        <= 1'b0;
      drain_pending <= 1'b0;
      done          <= 1'b0;
      rdata         <= 32'h0;
      addr_q        <= 32'h0;
      data_q        <= 32'h0;
      size_q        <= 2'd0;
      strobe_q      <= 4'h0;
      sign_ext_q    <= 1'b0;
      is_load_q     <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch sees the pre-edge values.
      done <= 1'b0;
      if (complete && cur_load && (in_idle || !kill_now)) begin
        rdata <= load_value;
      end
      unique case (state)
        IDLE: begin
          if (access) begin
            addr_q     <= addr;
            data_q     <= data_c;
            size_q     <= size;
            strobe_q   <= strobe_c;
            sign_ext_q <= sign_ext;
            is_load_q  <= mem_read;
            kill_q     <= 1'b0;
            if (dresp_addr_ok && dresp_data_ok) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (dresp_addr_ok) begin
              state <= WAIT;
            end else begin
              state <= REQ;
            end
          end
        end
        REQ: begin
          if (flush) kill_q <= 1'b1;
          if (dresp_addr_ok) begin
            if (kill_now) begin
              state         <= DRAIN;
              drain_pending <= ~dresp_data_ok;
            end else if (dresp_data_ok) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (flush) kill_q <= 1'b1;
          if (kill_now) begin
            state         <= DRAIN;
            drain_pending <= ~dresp_data_ok;
          end else if (dresp_data_ok) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          if (hold) begin
            done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        DRAIN: begin
          if (!drain_pending || dresp_data_ok) begin
            state         <= IDLE;
            drain_pending <= 1'b0;
            kill_q        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
